// File: rtl/stage_wb_pkg.sv
// Shared constants and types for the write-back stage.
package stage_wb_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Control fields carried in the MEM/WB register
  typedef struct packed {
    logic       mem_read;
    logic [2:0] func3;
    logic [4:0] rd;
    logic       reg_write;
  } wb_ctrl_t;

endpackage

// File: rtl/stage_wb_load_align.sv
// Load alignment: picks byte/halfword/word from the raw dmem word and extends it.
module load_align
  import stage_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      func3_i,
  output logic [XLEN-1:0] aligned_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  // Halfwords are selected by off[1] only, matching store alignment.
  assign byte_w = raw_i[{off_i, 3'b000} +: 8];
  assign half_w = raw_i[{off_i[1], 4'b0000} +: 16];

  // Extend the selected field according to the load type; unknown codes give 0.
  always_comb begin
    aligned_o = '0;
    case (func3_i)
      F3_LB:   aligned_o = {{(XLEN-8){byte_w[7]}}, byte_w};
      F3_LBU:  aligned_o = {{(XLEN-8){1'b0}}, byte_w};
      F3_LH:   aligned_o = {{(XLEN-16){half_w[15]}}, half_w};
      F3_LHU:  aligned_o = {{(XLEN-16){1'b0}}, half_w};
      F3_LW:   aligned_o = raw_i;
      default: aligned_o = '0;
    endcase
  end

endmodule

// File: rtl/stage_wb.sv
// Write-back stage: MEM/WB register, load-data hold buffer, result select,
// register-file write port and retired-instruction counter.
module stage_wb
  import stage_wb_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 me_valid,
  input  logic [XLEN-1:0]      me_alu_o,
  input  logic                 me_mem_read,
  input  logic [2:0]           me_func3_code,
  input  logic [4:0]           me_rd_addr,
  input  logic                 me_reg_write,
  input  logic [XLEN-1:0]      me_mem_data,
  input  logic                 wb_stall,
  input  logic                 wb_flush,
  output logic                 w_regs_en,
  output logic [4:0]           w_regs_addr,
  output logic [XLEN-1:0]      w_regs_data,
  output logic                 wb_busy,
  output logic [INSTRET_W-1:0] wb_instret
);

  logic                 wb_valid_q;
  logic [XLEN-1:0]      wb_alu_q;
  wb_ctrl_t             wb_ctrl_q;
  logic                 hold_vld_q;
  logic [XLEN-1:0]      hold_q;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0]      raw_w, aligned_w;
  logic                 retire_w;

  // MEM/WB register; a stall freezes everything, flush only kills the incoming valid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wb_valid_q <= 1'b0;
      wb_alu_q   <= '0;
      wb_ctrl_q  <= '0;
    end else if (!wb_stall) begin
      wb_valid_q <= me_valid & ~wb_flush;
      wb_alu_q   <= me_alu_o;
      wb_ctrl_q  <= '{mem_read:  me_mem_read,
                      func3:     me_func3_code,
                      rd:        me_rd_addr,
                      reg_write: me_reg_write};
    end
  end

  // Dmem data is only valid in the first WB cycle, so capture it when a stall begins.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else if (wb_stall && !hold_vld_q) begin
      hold_vld_q <= 1'b1;
      hold_q     <= me_mem_data;
    end else if (!wb_stall) begin
      hold_vld_q <= 1'b0;
    end
  end

  assign raw_w = hold_vld_q ? hold_q : me_mem_data;

  load_align #(.XLEN(XLEN)) u_align (
    .raw_i     (raw_w),
    .off_i     (wb_alu_q[1:0]),
    .func3_i   (wb_ctrl_q.func3),
    .aligned_o (aligned_w)
  );

  // An instruction retires on the one cycle it leaves WB unstalled.
  assign retire_w    = wb_valid_q & ~wb_stall;
  assign w_regs_en   = retire_w & wb_ctrl_q.reg_write & (wb_ctrl_q.rd != 5'd0);
  assign w_regs_addr = wb_ctrl_q.rd;
  assign w_regs_data = wb_ctrl_q.mem_read ? aligned_w : wb_alu_q;
  assign wb_busy     = wb_valid_q;
  assign wb_instret  = instret_q;

  assign instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rstn)         instret_q <= '0;
    else if (retire_w) instret_q <= instret_d;
  end

endmodule

// File: tb/tb_stage_wb.sv
// Self-checking bench for stage_wb: directed scenarios plus a randomized run
// against a per-instruction behavioural model.
module tb_stage_wb;

  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          me_valid;
  logic [31:0]   me_alu_o;
  logic          me_mem_read;
  logic [2:0]    me_func3_code;
  logic [4:0]    me_rd_addr;
  logic          me_reg_write;
  logic [31:0]   me_mem_data;
  logic          wb_stall;
  logic          wb_flush;
  logic          w_regs_en;
  logic [4:0]    w_regs_addr;
  logic [31:0]   w_regs_data;
  logic          wb_busy;
  logic [IW-1:0] wb_instret;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  stage_wb #(.XLEN(32), .INSTRET_W(IW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .me_valid      (me_valid),
    .me_alu_o      (me_alu_o),
    .me_mem_read   (me_mem_read),
    .me_func3_code (me_func3_code),
    .me_rd_addr    (me_rd_addr),
    .me_reg_write  (me_reg_write),
    .me_mem_data   (me_mem_data),
    .wb_stall      (wb_stall),
    .wb_flush      (wb_flush),
    .w_regs_en     (w_regs_en),
    .w_regs_addr   (w_regs_addr),
    .w_regs_data   (w_regs_data),
    .wb_busy       (wb_busy),
    .wb_instret    (wb_instret)
  );

  always #5 clk = ~clk;

  // Reference load semantics from the ISA: shift the addressed field down, mask, extend.
  function automatic logic [31:0] ref_load(logic [31:0] w, logic [31:0] a, logic [2:0] f);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      3'd2:    return w;
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_me(logic v, logic [31:0] alu, logic mr, logic [2:0] f3,
                        logic [4:0] rd, logic rw);
    me_valid = v; me_alu_o = alu; me_mem_read = mr;
    me_func3_code = f3; me_rd_addr = rd; me_reg_write = rw;
  endtask

  task automatic do_reset();
    rstn = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0;
    set_me(1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0);
    tick(); tick();
    rstn = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0;
    set_me(1'b1, $urandom, 1'b1, 3'd2, 5'd9, 1'b1);
    me_mem_data = $urandom;
    tick(); tick();
    @(negedge clk);
    checks++; if (w_regs_en !== 1'b0) begin failures++; $display("FAIL reset_en: got %b expected 0", w_regs_en); end
    checks++; if (w_regs_addr !== 5'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", w_regs_addr); end
    checks++; if (w_regs_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", w_regs_data); end
    checks++; if (wb_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", wb_busy); end
    checks++; if (wb_instret !== '0) begin failures++; $display("FAIL reset_instret: got %0d expected 0", wb_instret); end
    do_reset();
  endtask

  task automatic test_loads();
    logic [31:0] ad[5], wd[5], ex[5];
    logic [2:0]  fc[5];
    logic [31:0] a, w;
    logic [2:0]  f;
    ad = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h102};
    wd = '{32'h80FF_1234, 32'h80FF_1234, 32'h8001_7FFF, 32'h8001_7FFF, 32'h8001_7FFF};
    fc = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    ex = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h8001_7FFF};
    for (int i = 0; i < 5; i++) begin
      set_me(1'b1, ad[i], 1'b1, fc[i], 5'd10, 1'b1);
      tick();
      set_me(1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0);
      me_mem_data = wd[i];
      @(negedge clk);
      checks++; if (w_regs_data !== ex[i]) begin failures++; $display("FAIL load_data[%0d]: got %h expected %h", i, w_regs_data, ex[i]); end
      checks++; if (w_regs_en !== 1'b1 || w_regs_addr !== 5'd10) begin failures++; $display("FAIL load_wr[%0d]: got en=%b rd=%0d expected en=1 rd=10", i, w_regs_en, w_regs_addr); end
      tick();
      exp_cnt++;
      @(negedge clk);
      checks++; if (w_regs_en !== 1'b0) begin failures++; $display("FAIL load_once[%0d]: got en=%b expected 0", i, w_regs_en); end
      checks++; if (wb_instret !== IW'(exp_cnt)) begin failures++; $display("FAIL load_instret[%0d]: got %0d expected %0d", i, wb_instret, IW'(exp_cnt)); end
    end
    // Random loads, back to back, every funct3 including undefined ones
    for (int i = 0; i < 24; i++) begin
      a = $urandom; w = $urandom; f = 3'($urandom_range(0, 7));
      set_me(1'b1, a, 1'b1, f, 5'd3, 1'b1);
      tick();
      me_mem_data = w;
      @(negedge clk);
      checks++; if (w_regs_data !== ref_load(w, a, f)) begin failures++; $display("FAIL rand_load f3=%0d a=%h w=%h: got %h expected %h", f, a, w, w_regs_data, ref_load(w, a, f)); end
      exp_cnt++;
    end
    set_me(1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0);
    tick();
  endtask

  task automatic test_alu();
    set_me(1'b1, 32'h1234, 1'b0, 3'd0, 5'd5, 1'b1);
    tick();
    set_me(1'b1, 32'h5678, 1'b0, 3'd0, 5'd0, 1'b1);
    me_mem_data = $urandom;
    @(negedge clk);
    checks++; if (w_regs_en !== 1'b1 || w_regs_addr !== 5'd5 || w_regs_data !== 32'h1234) begin failures++; $display("FAIL alu_x5: got en=%b rd=%0d data=%h expected en=1 rd=5 data=00001234", w_regs_en, w_regs_addr, w_regs_data); end
    tick();
    exp_cnt++;
    set_me(1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (w_regs_en !== 1'b0) begin failures++; $display("FAIL alu_x0_en: got %b expected 0", w_regs_en); end
    tick();
    exp_cnt++;
    @(negedge clk);
    checks++; if (wb_instret !== IW'(exp_cnt)) begin failures++; $display("FAIL alu_x0_instret: got %0d expected %0d", wb_instret, IW'(exp_cnt)); end
  endtask

  task automatic test_stall();
    logic [31:0] w0;
    w0 = $urandom;
    set_me(1'b1, 32'h100, 1'b1, 3'b010, 5'd12, 1'b1);
    tick();
    set_me(1'b1, 32'h44, 1'b0, 3'd0, 5'd13, 1'b1);
    me_mem_data = w0;
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (w_regs_en !== 1'b0 || w_regs_data !== w0) begin failures++; $display("FAIL stall[%0d]: got en=%b data=%h expected en=0 data=%h", i, w_regs_en, w_regs_data, w0); end
      tick();
      me_mem_data = 32'hDEAD_BEEF;
    end
    wb_stall = 1'b0;
    set_me(1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (w_regs_en !== 1'b1 || w_regs_data !== w0 || w_regs_addr !== 5'd12) begin failures++; $display("FAIL stall_release: got en=%b rd=%0d data=%h expected en=1 rd=12 data=%h", w_regs_en, w_regs_addr, w_regs_data, w0); end
    tick();
    exp_cnt++;
    @(negedge clk);
    checks++; if (w_regs_en !== 1'b0 || wb_instret !== IW'(exp_cnt)) begin failures++; $display("FAIL stall_after: got en=%b instret=%0d expected en=0 instret=%0d", w_regs_en, wb_instret, IW'(exp_cnt)); end
  endtask

  task automatic test_flush();
    set_me(1'b1, 32'h77, 1'b0, 3'd0, 5'd6, 1'b1);
    wb_flush = 1'b1;
    tick();
    wb_flush = 1'b0;
    set_me(1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (wb_busy !== 1'b0 || w_regs_en !== 1'b0) begin failures++; $display("FAIL flush_kill: got busy=%b en=%b expected 0 0", wb_busy, w_regs_en); end
    tick();
    @(negedge clk);
    checks++; if (wb_instret !== IW'(exp_cnt)) begin failures++; $display("FAIL flush_instret: got %0d expected %0d", wb_instret, IW'(exp_cnt)); end
    // Flush together with stall must not kill the instruction already in WB
    set_me(1'b1, 32'hABCD, 1'b0, 3'd0, 5'd7, 1'b1);
    tick();
    set_me(1'b1, 32'h9999, 1'b0, 3'd0, 5'd8, 1'b1);
    wb_stall = 1'b1; wb_flush = 1'b1;
    tick();
    wb_stall = 1'b0; wb_flush = 1'b0;
    set_me(1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (wb_busy !== 1'b1 || w_regs_en !== 1'b1 || w_regs_addr !== 5'd7 || w_regs_data !== 32'hABCD) begin failures++; $display("FAIL flush_stall: got busy=%b en=%b rd=%0d data=%h expected 1 1 7 0000abcd", wb_busy, w_regs_en, w_regs_addr, w_regs_data); end
    tick();
    exp_cnt++;
    @(negedge clk);
    checks++; if (wb_instret !== IW'(exp_cnt)) begin failures++; $display("FAIL flush_stall_instret: got %0d expected %0d", wb_instret, IW'(exp_cnt)); end
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    set_me(1'b1, 32'h1, 1'b0, 3'd0, 5'd0, 1'b1);
    for (int i = 0; i < (1 << IW) - 1; i++) begin
      tick();
      @(negedge clk);
      checks++; if (wb_busy !== 1'b1 || wb_instret !== IW'(i)) begin failures++; $display("FAIL b2b[%0d]: got busy=%b instret=%0d expected busy=1 instret=%0d", i, wb_busy, wb_instret, IW'(i)); end
    end
    set_me(1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0);
    tick();
    @(negedge clk);
    checks++; if (wb_instret !== {IW{1'b1}}) begin failures++; $display("FAIL wrap_full: got %0d expected %0d", wb_instret, (1 << IW) - 1); end
    set_me(1'b1, 32'h2, 1'b0, 3'd0, 5'd1, 1'b1);
    tick();
    set_me(1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0);
    tick();
    @(negedge clk);
    checks++; if (wb_instret !== '0) begin failures++; $display("FAIL wrap_zero: got %0d expected 0", wb_instret); end
    exp_cnt = 0;
  endtask

  task automatic test_reset_in_stall();
    logic [31:0] w2;
    set_me(1'b1, 32'h200, 1'b1, 3'b010, 5'd14, 1'b1);
    tick();
    set_me(1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0);
    me_mem_data = 32'h1111_2222;
    wb_stall = 1'b1;
    tick();
    rstn = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (w_regs_en !== 1'b0 || w_regs_addr !== 5'd0 || w_regs_data !== 32'h0 || wb_busy !== 1'b0 || wb_instret !== '0) begin failures++; $display("FAIL reset_stall: got en=%b rd=%0d data=%h busy=%b instret=%0d expected all 0", w_regs_en, w_regs_addr, w_regs_data, wb_busy, wb_instret); end
    rstn = 1'b1; wb_stall = 1'b0; exp_cnt = 0;
    w2 = $urandom;
    set_me(1'b1, 32'h300, 1'b1, 3'b010, 5'd15, 1'b1);
    tick();
    set_me(1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0);
    me_mem_data = w2;
    @(negedge clk);
    checks++; if (w_regs_data !== w2 || w_regs_en !== 1'b1) begin failures++; $display("FAIL reset_stall_new: got en=%b data=%h expected en=1 data=%h", w_regs_en, w_regs_data, w2); end
    tick();
    exp_cnt++;
  endtask

  // Randomized run: the model tracks the instruction occupying WB and the
  // dmem word it saw on its first cycle there.
  task automatic test_random();
    logic        m_v, m_mr, m_rw, m_fresh;
    logic [31:0] m_alu, m_first, e_data;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd;
    logic        e_en;
    do_reset();
    m_v = 1'b0; m_fresh = 1'b1; m_mr = 1'b0; m_rw = 1'b0;
    m_alu = '0; m_f3 = '0; m_rd = '0; m_first = '0;
    for (int i = 0; i < 400; i++) begin
      set_me(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 3'($urandom_range(0, 7)),
             5'($urandom), 1'($urandom_range(0, 3) != 0));
      me_mem_data = $urandom;
      wb_stall = ($urandom_range(0, 9) < 3);
      wb_flush = ($urandom_range(0, 9) < 2);
      @(negedge clk);
      if (m_fresh) begin m_first = me_mem_data; m_fresh = 1'b0; end
      e_en   = m_v && !wb_stall && m_rw && (m_rd != 5'd0);
      e_data = m_mr ? ref_load(m_first, m_alu, m_f3) : m_alu;
      checks++; if (w_regs_en !== e_en || wb_busy !== m_v || wb_instret !== IW'(exp_cnt)) begin failures++; $display("FAIL rand_ctl[%0d]: got en=%b busy=%b instret=%0d expected en=%b busy=%b instret=%0d", i, w_regs_en, wb_busy, wb_instret, e_en, m_v, IW'(exp_cnt)); end
      if (m_v) begin
        checks++; if (w_regs_addr !== m_rd || w_regs_data !== e_data) begin failures++; $display("FAIL rand_data[%0d]: got rd=%0d data=%h expected rd=%0d data=%h", i, w_regs_addr, w_regs_data, m_rd, e_data); end
      end
      @(posedge clk);
      if (m_v && !wb_stall) exp_cnt++;
      if (!wb_stall) begin
        m_v = me_valid && !wb_flush; m_alu = me_alu_o; m_mr = me_mem_read;
        m_f3 = me_func3_code; m_rd = me_rd_addr; m_rw = me_reg_write; m_fresh = 1'b1;
      end
      #1;
    end
    wb_stall = 1'b0; wb_flush = 1'b0;
    set_me(1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0; me_mem_data = '0;
    set_me(1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0);
    #1;
    test_reset();
    test_loads();
    test_alu();
    test_stall();
    test_flush();
    test_back_to_back_wrap();
    test_reset_in_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_wb.md
Name: stage_wb

Overview:
- Write-back stage of the 5-stage RV32 core, directly downstream of the memory stage.
- Holds the MEM/WB pipeline register and aligns and sign-extends load data, which the data memory returns one cycle after the access.
- Selects between ALU result and load data, and drives the register-file write port and the forwarding bus.
- Keeps a retired-instruction counter.

Parameters:
XLEN, 32, datapath width
INSTRET_W, 64, width of retired-instruction counter

Ports:
clk  in  1  core clock
rstn  in  1  synchronous active-low reset, sampled on posedge clk
me_valid  in  1  instruction in ME is valid
me_alu_o  in  XLEN  ALU result / effective address from ME
me_mem_read  in  1  ME instruction is a load
me_func3_code  in  3  funct3 of ME instruction
me_rd_addr  in  5  destination register
me_reg_write  in  1  ME instruction writes rd
me_mem_data  in  XLEN  raw dmem read word; valid in the cycle after the ME access
wb_stall  in  1  hold WB contents (downstream/hazard stall)
wb_flush  in  1  discard the instruction entering WB this edge
w_regs_en  out  1  register-file write enable
w_regs_addr  out  5  register-file write address
w_regs_data  out  XLEN  register-file write data; also the forwarding value
wb_busy  out  1  WB holds a valid instruction (wb_valid_q)
wb_instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset: all registers clear on posedge clk while rstn==0, including wb_valid_q, wb_instret, hold_vld_q and hold_q. Outputs under reset: w_regs_en=0, w_regs_addr=0, w_regs_data=0, wb_busy=0, wb_instret=0. A reset mid-stall discards the held instruction and the hold buffer.
- Pipeline register fields: valid, alu_o, mem_read, func3, rd, reg_write.
  - Update at posedge when wb_stall==0.
  - wb_valid_q <= me_valid & ~wb_flush.
  - Other fields load unconditionally.
- wb_stall==1: every pipeline field holds. wb_stall has priority over wb_flush; flush never kills the instruction already in WB.
- Load data hold buffer:
  - On the first stalled cycle (wb_stall==1 and hold_vld_q==0), capture hold_q <= me_mem_data and set hold_vld_q.
  - hold_vld_q clears on the first cycle with wb_stall==0.
  - Effective raw word: raw = hold_vld_q ? hold_q : me_mem_data.
  - Net effect: data returned in the first WB cycle is used for the whole stall.
- Load alignment uses off = alu_o[1:0]:
  - LB (000): sign-extend raw byte[off].
  - LBU (100): zero-extend raw byte[off].
  - LH (001): sign-extend halfword at off[1].
  - LHU (101): zero-extend halfword at off[1].
  - LW (010): raw; off ignored.
  - Other func3 codes: 0.
  - Halfwords use off[1] only and byte addresses ignore nothing else; this matches the store alignment rules.
- Output selection:
  - w_regs_data = mem_read ? aligned : alu_o. Combinational, valid whenever wb_valid_q.
  - w_regs_addr = rd.
- Retire: retire = wb_valid_q & ~wb_stall.
  - w_regs_en = retire & reg_write & (rd != 0). Asserted exactly once per instruction.
  - wb_instret increments by 1 on each posedge where retire==1, and wraps from all-ones to 0.
- Latency: an instruction in ME at cycle N writes the register file in cycle N+1, absent a stall.
- Back-to-back loads are supported at full throughput.

Decomposition:
- Shared package/define file holds the load funct3 constants (LB, LH, LW, LBU, LHU), alongside the existing SB/SH/SW.
- One sub-module, load_align: combinational, takes raw, off and func3; produces the aligned word.
- The rest (pipeline register, hold buffer, instret counter) lives in stage_wb.

Test Plan:
1. LB at address 0x103, dmem word 0x80FF_1234 next cycle -> w_regs_data=0xFFFF_FF80, w_regs_en=1 for one cycle. Same access as LBU -> 0x0000_0080.
2. LH at address 0x102, word 0x8001_7FFF -> 0xFFFF_8001. LHU -> 0x0000_8001. LW -> 0x8001_7FFF.
3. ALU op with rd=5, alu_o=0x1234 -> writes 0x1234 to x5. Same op with rd=0 -> w_regs_en=0, but wb_instret still increments.
4. Load in WB, stall for 3 cycles while me_mem_data changes to 0xDEAD_BEEF -> w_regs_data keeps the original word. w_regs_en=0 during the stall, then 1 exactly once; wb_instret +1 total.
5. wb_flush with me_valid=1 and no stall -> next cycle wb_busy=0, no write, counter unchanged. flush+stall together -> held instruction retires normally.
6. Preload wb_instret near wrap by retiring 2^INSTRET_W-1 instructions (small-width override in sim), retire once more -> 0. Assert rstn=0 during a stall -> all outputs 0 next cycle and the hold buffer is cleared.
